// File: rtl/load_scoreboard.sv
// Load hazard scoreboard between ID and EX: tracks in-order outstanding load
// destinations and stalls ID on RAW/WAW hazards against them or when the queue is full.
module load_scoreboard #(
  parameter int RF_SIZE = 5,
  parameter int DEPTH   = 4,
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Valid_ex,
  input  logic               EnMemR_ex,
  input  logic               EnRd_ex,
  input  logic [RF_SIZE-1:0] RdIdx_ex,
  input  logic               Valid_id,
  input  logic               EnMemR_id,
  input  logic               EnRd_id,
  input  logic [RF_SIZE-1:0] RdIdx_id,
  input  logic [RF_SIZE-1:0] Rs1Idx_id,
  input  logic [RF_SIZE-1:0] Rs2Idx_id,
  input  logic               flush,
  input  logic               mem_resp_valid,
  output logic               stall,
  output logic [CW-1:0]      ld_pending,
  output logic               resp_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [RF_SIZE-1:0] rd_q [DEPTH];
  logic [RF_SIZE-1:0] rd_d [DEPTH];
  logic               resp_err_q, resp_err_d;

  logic               push, pop, push_ok;
  logic [DEPTH-1:0]   hit_rs1, hit_rs2, hit_rd;
  logic               ex_rs1, ex_rs2, ex_rd;
  logic               raw, waw, full;
  logic [CW:0]        occ_next;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push    = Valid_ex & EnMemR_ex & EnRd_ex & (RdIdx_ex != '0) & ~flush;
  assign pop     = mem_resp_valid & (count_q != '0);
  // A push into a full queue without a simultaneous pop is a protocol error; drop it.
  assign push_ok = push & (pop | (count_q != CW'(DEPTH)));

  // The head entry being popped this cycle is forwarded, so it no longer blocks.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      logic live;
      assign live        = valid_q[gi] & ~(pop & (head_q == PW'(gi)));
      assign hit_rs1[gi] = live & (rd_q[gi] == Rs1Idx_id);
      assign hit_rs2[gi] = live & (rd_q[gi] == Rs2Idx_id);
      assign hit_rd[gi]  = live & (rd_q[gi] == RdIdx_id);
    end
  endgenerate

  assign ex_rs1   = push & (RdIdx_ex == Rs1Idx_id);
  assign ex_rs2   = push & (RdIdx_ex == Rs2Idx_id);
  assign ex_rd    = push & (RdIdx_ex == RdIdx_id);

  assign raw      = ((Rs1Idx_id != '0) & ((|hit_rs1) | ex_rs1)) |
                    ((Rs2Idx_id != '0) & ((|hit_rs2) | ex_rs2));
  assign waw      = EnRd_id & (RdIdx_id != '0) & ((|hit_rd) | ex_rd);
  assign occ_next = {1'b0, count_q} + (CW+1)'(push) - (CW+1)'(pop);
  assign full     = EnMemR_id & (occ_next == (CW+1)'(DEPTH));

  assign stall      = ~rst & Valid_id & ~flush & (raw | waw | full);
  assign ld_pending = count_q;
  assign resp_err   = resp_err_q;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    valid_d    = valid_q;
    rd_d       = rd_q;
    count_d    = count_q + CW'(push_ok) - CW'(pop);
    resp_err_d = resp_err_q | (mem_resp_valid & (count_q == '0));
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = nxt(head_q);
    end
    if (push_ok) begin
      valid_d[tail_q] = 1'b1;
      rd_d[tail_q]    = RdIdx_ex;
      tail_d          = nxt(tail_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      resp_err_q <= resp_err_d;
    end
  end

  // Entry payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    rd_q <= rd_d;
  end

endmodule

// File: doc/load_scoreboard.md
# load_scoreboard

Parametrised load-hazard unit for the pipeline, placed between ID and EX. It generalises single-cycle load-use detection to a memory system with variable, in-order load latency. Issued loads are tracked in a DEPTH-entry in-order queue of destination indices. ID is stalled while any source (RAW) or destination (WAW) register has an outstanding load, or while the queue cannot accept another load.

## Interface
Parameters:
- RF_SIZE, 5, register index width (from pipeline_pkg).
- DEPTH, 4, maximum outstanding loads (≥1).
- CW, $clog2(DEPTH+1), occupancy counter width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- Valid_ex  in  1  EX holds a live instruction.
- EnMemR_ex  in  1  EX instruction is a load.
- EnRd_ex  in  1  EX instruction writes rd.
- RdIdx_ex  in  RF_SIZE  EX rd.
- Valid_id  in  1  ID holds a live instruction.
- EnMemR_id  in  1  ID instruction is a load.
- EnRd_id  in  1  ID instruction writes rd.
- RdIdx_id  in  RF_SIZE  ID rd.
- Rs1Idx_id  in  RF_SIZE  ID rs1 (0 = unused).
- Rs2Idx_id  in  RF_SIZE  ID rs2 (0 = unused).
- flush  in  1  kill ID and EX this cycle.
- mem_resp_valid  in  1  oldest outstanding load returns data this cycle; data is forwardable the same cycle.
- stall  out  1  hold PC/IF/ID, insert bubble into EX.
- ld_pending  out  CW  current queue occupancy.
- resp_err  out  1  sticky: response arrived with empty queue.

## Operation
- Queue: circular buffer of DEPTH entries {rd}, head/tail pointers, count.
- push = Valid_ex & EnMemR_ex & EnRd_ex & (RdIdx_ex != 0) & ~flush. Pushes RdIdx_ex at tail.
- pop = mem_resp_valid & (count != 0). Pops head.
- Push and pop in the same cycle are both performed; count is unchanged.
- mem_resp_valid with count == 0: no pop; resp_err set, held until rst.
- Match set for register r (r != 0): any valid queue entry with rd == r, excluding the head entry when pop is asserted (forwarded), plus the EX load (push term) with RdIdx_ex == r.
- raw = Rs1Idx_id or Rs2Idx_id (nonzero) in the match set.
- waw = EnRd_id & RdIdx_id != 0 & RdIdx_id in the match set.
- full = EnMemR_id & (count + push − pop == DEPTH).
- stall = Valid_id & ~flush & (raw | waw | full).
- Duplicate rd entries are legal. A register stays matched until its last entry pops.
- The queue is never flushed: loads past EX are architecturally committed to memory.

## Timing
- stall is combinational from inputs and current queue state. There are no registered outputs except ld_pending and resp_err.
- Reset (async assert): head = tail = 0, count = 0, ld_pending = 0, resp_err = 0; stall = 0 while reset is asserted.
- Push is visible in the queue on the next edge. Before that edge, the EX term covers the hazard, so a dependent instruction directly behind a load stalls with no gap.
- Minimum load-use penalty: 1 cycle, when the response arrives in the cycle after the load leaves EX. Each further latency cycle adds one stall cycle.
- Pointers wrap modulo DEPTH. count saturates logically at DEPTH, never exceeding it, guaranteed by the full term.
- Push at count == DEPTH without a pop cannot occur by construction. If it does (protocol violation), push is dropped.
- Reset mid-operation discards all entries. Responses after reset set resp_err.

## Test plan
- Back-to-back use: load x5 in EX, ID reads rs1 = x5, no response → stall = 1. Next cycle, mem_resp_valid = 1 → stall = 0, ld_pending returns to 0.
- Long latency: load x7, response after 4 cycles. ID reads rs2 = x7 → stall high exactly 4 cycles after push, low in the response cycle.
- x0 and flush: load to x0 → no push, stall = 0. Load x3 with flush = 1 → ld_pending stays 0.
- WAW and duplicates: loads x9, x9 outstanding. ID writes x9 → stall until the second response, not the first.
- Full: DEPTH = 4, four loads outstanding, ID load → stall = 1. Same cycle response → stall = 0, count stays 4 after push.
- Error and reset: mem_resp_valid with empty queue → resp_err = 1 and sticky. Assert rst mid-stream with 2 pending → ld_pending = 0, resp_err = 0 immediately.
